// File: rtl/mario_input_cond_if.sv
// Cabinet-input bundle: raw hps_io joystick words and VBLANK in, active-low switch bytes out.
interface mario_input_cond_if;
    logic        I_VBLANK;
    logic [15:0] I_JOY0;
    logic [15:0] I_JOY1;
    logic [7:0]  O_SW1;
    logic [7:0]  O_SW2;
    logic [1:0]  O_COIN_ST;

    modport master (output I_VBLANK, I_JOY0, I_JOY1, input  O_SW1, O_SW2, O_COIN_ST);
    modport slave  (input  I_VBLANK, I_JOY0, I_JOY1, output O_SW1, O_SW2, O_COIN_ST);
endinterface

// File: rtl/mario_input_cond.sv
// Conditions hps_io joystick words into mario_top I_SW1/I_SW2: 2-way left/right arbitration,
// debounced start/test/coin, and a VBLANK-locked coin pulse shaper.
module mario_input_cond #(
    parameter int unsigned DEBOUNCE_CYC     = 24000,
    parameter int unsigned COIN_HOLD_FRAMES = 3,
    parameter int unsigned COIN_GAP_FRAMES  = 3
) (
    input  logic              I_CLK_24M,
    input  logic              I_RESETn,
    mario_input_cond_if.slave bus
);
    localparam int unsigned DB_N    = 4;   // {coin, test, start2, start1}
    localparam int unsigned DB_COIN = 3;
    localparam int unsigned DB_W    = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned FR_MX   = (COIN_HOLD_FRAMES > COIN_GAP_FRAMES) ? COIN_HOLD_FRAMES
                                                                          : COIN_GAP_FRAMES;
    localparam int unsigned FR_W    = (FR_MX > 2) ? $clog2(FR_MX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } coin_st_e;

    logic [1:0]      s1_r, s1_l, s1_r_d, s1_l_d, s1_jump;
    logic [DB_N-1:0] s1_db, deb, flip_c;
    logic [DB_W-1:0] db_cnt [DB_N];
    logic            s1_vb, s1_vb_d;
    logic [1:0][1:0] last_q, last_nxt_c, lr_c;
    coin_st_e        coin_st;
    logic [FR_W-1:0] fcnt;
    logic            pending;
    logic [7:0]      sw1_q, sw2_q;
    logic            tick_c, coin_up_c;
    logic            unused_joy;

    assign unused_joy = ^{bus.I_JOY0[15:9], bus.I_JOY0[3:2], bus.I_JOY1[15:9], bus.I_JOY1[3:2]};

    // Stage 1: register every used input bit once; keep previous R/L/VBLANK for edge detection
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            s1_r    <= '0;
            s1_l    <= '0;
            s1_r_d  <= '0;
            s1_l_d  <= '0;
            s1_jump <= '0;
            s1_db   <= '0;
            s1_vb   <= 1'b0;
            s1_vb_d <= 1'b0;
        end else begin
            s1_r    <= {bus.I_JOY1[0], bus.I_JOY0[0]};
            s1_l    <= {bus.I_JOY1[1], bus.I_JOY0[1]};
            s1_r_d  <= s1_r;
            s1_l_d  <= s1_l;
            s1_jump <= {bus.I_JOY1[4], bus.I_JOY0[4]};
            s1_db   <= {bus.I_JOY0[7] | bus.I_JOY1[7], bus.I_JOY0[8] | bus.I_JOY1[8],
                        bus.I_JOY0[6] | bus.I_JOY1[6], bus.I_JOY0[5] | bus.I_JOY1[5]};
            s1_vb   <= bus.I_VBLANK;
            s1_vb_d <= s1_vb;
        end
    end

    // Most recently pressed direction wins while both are held; L wins a same-cycle tie
    always_comb begin
        last_nxt_c = last_q;
        lr_c       = '0;
        for (int p = 0; p < 2; p++) begin
            if (s1_l[p] && !s1_l_d[p])      last_nxt_c[p] = 2'b10;
            else if (s1_r[p] && !s1_r_d[p]) last_nxt_c[p] = 2'b01;
            lr_c[p] = (s1_l[p] && s1_r[p]) ? last_nxt_c[p] : {s1_l[p], s1_r[p]};
        end
    end

    always_comb begin
        flip_c = '0;
        for (int i = 0; i < int'(DB_N); i++)
            flip_c[i] = (s1_db[i] != deb[i]) && (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1));
        coin_up_c = flip_c[DB_COIN] && s1_db[DB_COIN];
        tick_c    = s1_vb && !s1_vb_d;
    end

    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            last_q <= '0;
            deb    <= '0;
            for (int i = 0; i < int'(DB_N); i++) db_cnt[i] <= '0;
        end else begin
            last_q <= last_nxt_c;
            for (int i = 0; i < int'(DB_N); i++) begin
                if (s1_db[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (flip_c[i]) begin
                    deb[i]    <= s1_db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Coin shaper: hold for whole frames, then force a released gap; at most one coin queued
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            coin_st <= ST_IDLE;
            fcnt    <= '0;
            pending <= 1'b0;
        end else begin
            case (coin_st)
                ST_IDLE: begin
                    if (coin_up_c || pending) begin
                        coin_st <= ST_ACTIVE;
                        fcnt    <= '0;
                        pending <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (coin_up_c) pending <= 1'b1;
                    if (tick_c) begin
                        if (fcnt == FR_W'(COIN_HOLD_FRAMES - 1)) begin
                            coin_st <= ST_GAP;
                            fcnt    <= '0;
                        end else begin
                            fcnt <= fcnt + FR_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (coin_up_c) pending <= 1'b1;
                    if (tick_c) begin
                        if (fcnt == FR_W'(COIN_GAP_FRAMES - 1)) begin
                            coin_st <= ST_IDLE;
                            fcnt    <= '0;
                        end else begin
                            fcnt <= fcnt + FR_W'(1);
                        end
                    end
                end
                default: begin
                    coin_st <= ST_IDLE;
                    fcnt    <= '0;
                end
            endcase
        end
    end

    // Stage 2: active-low switch bytes; unused cabinet bits stay high
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            sw1_q <= 8'hFF;
            sw2_q <= 8'hFF;
        end else begin
            sw1_q <= {~deb[2], ~deb[1], ~deb[0], ~s1_jump[0], 2'b11, ~lr_c[0]};
            sw2_q <= {2'b11, ~(coin_st == ST_ACTIVE), ~s1_jump[1], 2'b11, ~lr_c[1]};
        end
    end

    assign bus.O_SW1     = sw1_q;
    assign bus.O_SW2     = sw2_q;
    assign bus.O_COIN_ST = 2'(coin_st);
endmodule
